// File: rtl/cpu_v9_pkg.sv
// Shared types for the cpu_v9 core: opcode and FSM state enums plus
// instruction-field position helpers derived from the core parameters.
package cpu_v9_pkg;

    localparam int OPCODE_WIDTH = 4;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_MOV  = 4'h2,
        OP_ADD  = 4'h3,
        OP_SUB  = 4'h4,
        OP_AND  = 4'h5,
        OP_OR   = 4'h6,
        OP_XOR  = 4'h7,
        OP_SHL  = 4'h8,
        OP_IN   = 4'h9,
        OP_OUT  = 4'hA,
        OP_JMP  = 4'hB,
        OP_JZ   = 4'hC,
        OP_JC   = 4'hD,
        OP_NOP2 = 4'hE,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        ST_FETCH    = 2'd0,
        ST_EXEC     = 2'd1,
        ST_OUT_WAIT = 2'd2,
        ST_HALT     = 2'd3
    } state_e;

    // Register fields are packed directly below the opcode, rd first.
    function automatic int opcode_msb(input int iw);
        return iw - 1;
    endfunction

    function automatic int rd_msb(input int iw);
        return iw - OPCODE_WIDTH - 1;
    endfunction

    function automatic int ra_msb(input int iw, input int rw);
        return rd_msb(iw) - rw;
    endfunction

    function automatic int rb_msb(input int iw, input int rw);
        return ra_msb(iw, rw) - rw;
    endfunction

    function automatic logic updates_flags(input opcode_e op);
        return (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL});
    endfunction

endpackage

// File: rtl/cpu_v9_if.sv
// Board-side bus of the cpu_v9 core: program ROM port, input and output
// valid/ready ports and the halted status flag.
interface cpu_v9_if #(
    parameter int INSTR_WIDTH      = 16,
    parameter int INSTR_ADDR_WIDTH = 6,
    parameter int BUS_WIDTH        = 8
) ();

    logic [INSTR_ADDR_WIDTH-1:0] imem_addr;
    logic [INSTR_WIDTH-1:0]      imem_data;
    logic [BUS_WIDTH-1:0]        in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic [BUS_WIDTH-1:0]        out_data;
    logic                        out_valid;
    logic                        out_ready;
    logic                        halted;

    modport master (
        output imem_addr,
        input  imem_data,
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready,
        output halted
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  halted
    );

endinterface

// File: rtl/cpu_v9_alu.sv
// Combinational ALU for cpu_v9: computes result and Z/C for ADD..SHL.
// Other opcodes yield zero; the core ignores the outputs for them.
module cpu_v9_alu
    import cpu_v9_pkg::*;
#(
    parameter int BUS_WIDTH = 8
) (
    input  logic [BUS_WIDTH-1:0] a_i,
    input  logic [BUS_WIDTH-1:0] b_i,
    input  opcode_e              op_i,
    output logic [BUS_WIDTH-1:0] result_o,
    output logic                 z_o,
    output logic                 c_o
);

    // One extra bit holds carry, borrow or the bit shifted out of SHL.
    logic [BUS_WIDTH:0] wide_s;

    // Operation select on a widened datapath.
    always_comb begin
        wide_s = '0;
        case (op_i)
            OP_ADD:  wide_s = {1'b0, a_i} + {1'b0, b_i};
            OP_SUB:  wide_s = {1'b0, a_i} - {1'b0, b_i};
            OP_AND:  wide_s = {1'b0, a_i & b_i};
            OP_OR:   wide_s = {1'b0, a_i | b_i};
            OP_XOR:  wide_s = {1'b0, a_i ^ b_i};
            OP_SHL:  wide_s = {a_i, 1'b0};
            default: wide_s = '0;
        endcase
    end

    assign result_o = wide_s[BUS_WIDTH-1:0];
    assign c_o      = wide_s[BUS_WIDTH];
    assign z_o      = (wide_s[BUS_WIDTH-1:0] == '0);

endmodule

// File: rtl/cpu_v9.sv
// cpu_v9 multi-cycle core: FETCH/EXEC/OUT_WAIT/HALT with register file and Z/C flags.
// Optional CPU_BRANCH_EN macro enables JZ/JC; otherwise they act as NOP.
// INSTR_WIDTH must be >= 4+REG_ADDR_WIDTH+BUS_WIDTH and >= 4+3*REG_ADDR_WIDTH.
module cpu_v9
    import cpu_v9_pkg::*;
#(
    parameter int INSTR_WIDTH      = 16,
    parameter int INSTR_ADDR_WIDTH = 6,
    parameter int REG_ADDR_WIDTH   = 3,
    parameter int BUS_WIDTH        = 8
) (
    input  logic     clk,
    input  logic     n_reset,
    cpu_v9_if.master bus
);

    localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;
    localparam int OP_MSB   = opcode_msb(INSTR_WIDTH);
    localparam int RD_MSB   = rd_msb(INSTR_WIDTH);
    localparam int RA_MSB   = ra_msb(INSTR_WIDTH, REG_ADDR_WIDTH);
    localparam int RB_MSB   = rb_msb(INSTR_WIDTH, REG_ADDR_WIDTH);
    localparam logic [INSTR_ADDR_WIDTH-1:0] PC_ONE = {{(INSTR_ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_e                      state_q, state_d;
    logic [INSTR_ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [INSTR_WIDTH-1:0]      ir_q, ir_d;
    logic                        z_q, z_d;
    logic                        c_q, c_d;
    logic [BUS_WIDTH-1:0]        out_data_q, out_data_d;
    logic                        out_valid_q, out_valid_d;
    logic                        in_ready_q, in_ready_d;
    logic                        halted_q, halted_d;
    logic [BUS_WIDTH-1:0]        regs_q [NUM_REGS];

    opcode_e                     op_s;
    logic [REG_ADDR_WIDTH-1:0]   rd_idx_s;
    logic [REG_ADDR_WIDTH-1:0]   ra_idx_s;
    logic [REG_ADDR_WIDTH-1:0]   rb_idx_s;
    logic [BUS_WIDTH-1:0]        ra_val_s;
    logic [BUS_WIDTH-1:0]        rb_val_s;
    logic [BUS_WIDTH-1:0]        imm_s;
    logic [INSTR_ADDR_WIDTH-1:0] target_s;
    logic [INSTR_ADDR_WIDTH-1:0] pc_inc_s;
    logic [BUS_WIDTH-1:0]        alu_result_s;
    logic                        alu_z_s;
    logic                        alu_c_s;
    logic                        wr_en_s;
    logic [BUS_WIDTH-1:0]        wr_data_s;

    assign op_s     = opcode_e'(ir_q[OP_MSB -: OPCODE_WIDTH]);
    assign rd_idx_s = ir_q[RD_MSB -: REG_ADDR_WIDTH];
    assign ra_idx_s = ir_q[RA_MSB -: REG_ADDR_WIDTH];
    assign rb_idx_s = ir_q[RB_MSB -: REG_ADDR_WIDTH];
    assign imm_s    = ir_q[BUS_WIDTH-1:0];
    assign target_s = ir_q[INSTR_ADDR_WIDTH-1:0];
    assign pc_inc_s = pc_q + PC_ONE;
    assign ra_val_s = regs_q[ra_idx_s];
    assign rb_val_s = regs_q[rb_idx_s];

    cpu_v9_alu #(
        .BUS_WIDTH (BUS_WIDTH)
    ) u_alu (
        .a_i      (ra_val_s),
        .b_i      (rb_val_s),
        .op_i     (op_s),
        .result_o (alu_result_s),
        .z_o      (alu_z_s),
        .c_o      (alu_c_s)
    );

`ifndef CPU_BRANCH_EN
    // Flags are still maintained without conditional branches but never consumed.
    logic unused_flags_s;
    assign unused_flags_s = z_q ^ c_q;
`endif

    // Next-state, datapath and port control for every FSM state.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        z_d         = z_q;
        c_d         = c_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        halted_d    = halted_q;
        wr_en_s     = 1'b0;
        wr_data_s   = '0;
        case (state_q)
            ST_FETCH: begin
                ir_d       = bus.imem_data;
                in_ready_d = (opcode_e'(bus.imem_data[OP_MSB -: OPCODE_WIDTH]) == OP_IN);
                state_d    = ST_EXEC;
            end
            ST_EXEC: begin
                pc_d    = pc_inc_s;
                state_d = ST_FETCH;
                case (op_s)
                    OP_LDI: begin
                        wr_en_s   = 1'b1;
                        wr_data_s = imm_s;
                    end
                    OP_MOV: begin
                        wr_en_s   = 1'b1;
                        wr_data_s = ra_val_s;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL: begin
                        wr_en_s   = 1'b1;
                        wr_data_s = alu_result_s;
                        z_d       = alu_z_s;
                        c_d       = alu_c_s;
                    end
                    OP_IN: begin
                        if (bus.in_valid && in_ready_q) begin
                            wr_en_s    = 1'b1;
                            wr_data_s  = bus.in_data;
                            in_ready_d = 1'b0;
                        end else begin
                            pc_d    = pc_q;
                            state_d = ST_EXEC;
                        end
                    end
                    OP_OUT: begin
                        out_data_d  = ra_val_s;
                        out_valid_d = 1'b1;
                        state_d     = ST_OUT_WAIT;
                    end
                    OP_JMP: pc_d = target_s;
`ifdef CPU_BRANCH_EN
                    OP_JZ: begin
                        if (z_q) begin
                            pc_d = target_s;
                        end else begin
                            pc_d = pc_inc_s;
                        end
                    end
                    OP_JC: begin
                        if (c_q) begin
                            pc_d = target_s;
                        end else begin
                            pc_d = pc_inc_s;
                        end
                    end
`else
                    OP_JZ, OP_JC: pc_d = pc_inc_s;
`endif
                    OP_HALT: begin
                        pc_d     = pc_q;
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end
                    OP_NOP, OP_NOP2: pc_d = pc_inc_s;
                    default: pc_d = pc_inc_s;
                endcase
            end
            ST_OUT_WAIT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_FETCH;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            ST_HALT: begin
                halted_d = 1'b1;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // Control and port registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= ST_FETCH;
            pc_q        <= '0;
            ir_q        <= '0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            z_q         <= z_d;
            c_q         <= c_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            halted_q    <= halted_d;
        end
    end

    // Register file; operands were read combinationally before this write lands.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_s) begin
            regs_q[rd_idx_s] <= wr_data_s;
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.halted    = halted_q;

endmodule

// File: tb/tb_cpu_v9.sv
// Scoreboard bench for cpu_v9: an instruction-level model predicts OUT values,
// IN consumption and the HALT address; monitors check the port handshakes.
module tb_cpu_v9;
    import cpu_v9_pkg::*;

    localparam int IW = 16;
    localparam int AW = 6;
    localparam int RW = 3;
    localparam int BW = 8;
    localparam int ROM_DEPTH = 64;
`ifdef CPU_BRANCH_EN
    localparam bit BRANCH_EN = 1'b1;
`else
    localparam bit BRANCH_EN = 1'b0;
`endif

    logic clk;
    logic n_reset;
    logic [IW-1:0] rom [ROM_DEPTH];

    cpu_v9_if #(.INSTR_WIDTH(IW), .INSTR_ADDR_WIDTH(AW), .BUS_WIDTH(BW)) bus ();

    cpu_v9 #(
        .INSTR_WIDTH(IW), .INSTR_ADDR_WIDTH(AW), .REG_ADDR_WIDTH(RW), .BUS_WIDTH(BW)
    ) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    assign bus.imem_data = rom[bus.imem_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int passed = 0;
    int exp_q[$];
    int in_vals[$];
    int in_idx = 0;
    int exp_halt_pc;
    int exp_in_cnt;
    int force_istall = -1;
    int force_ostall = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    endtask

    function automatic logic [IW-1:0] enc_r(input int op, input int rd, input int ra, input int rb);
        return {op[3:0], rd[2:0], ra[2:0], rb[2:0], 3'b000};
    endfunction

    function automatic logic [IW-1:0] enc_i(input int op, input int rd, input int imm);
        return {op[3:0], rd[2:0], 1'b0, imm[7:0]};
    endfunction

    function automatic logic [IW-1:0] enc_j(input int op, input int tgt);
        return {op[3:0], 6'b000000, tgt[5:0]};
    endfunction

    function automatic int pick_istall();
        return (force_istall >= 0) ? force_istall : int'($urandom_range(0, 3));
    endfunction

    function automatic int pick_ostall();
        return (force_ostall >= 0) ? force_ostall : int'($urandom_range(0, 3));
    endfunction

    // Instruction-set interpreter: fills exp_q, returns halt address and IN count.
    task automatic model_run(output int halt_pc, output int n_in);
        int r[8];
        int pc, nxt, z, c, res, a, b, op, rd, ra, rb;
        logic [IW-1:0] w;
        foreach (r[i]) r[i] = 0;
        pc = 0; z = 0; c = 0; n_in = 0; halt_pc = -1;
        exp_q.delete();
        for (int s = 0; s < 2000; s++) begin
            w  = rom[pc];
            op = int'(w[15:12]); rd = int'(w[11:9]); ra = int'(w[8:6]); rb = int'(w[5:3]);
            a  = r[ra]; b = r[rb];
            nxt = (pc + 1) % ROM_DEPTH;
            case (op)
                1: r[rd] = int'(w[7:0]);
                2: r[rd] = a;
                3, 4, 5, 6, 7, 8: begin
                    case (op)
                        3: begin res = a + b; c = (res > 255) ? 1 : 0; end
                        4: begin res = a - b; c = (a < b) ? 1 : 0; end
                        5: begin res = a & b; c = 0; end
                        6: begin res = a | b; c = 0; end
                        7: begin res = a ^ b; c = 0; end
                        default: begin res = a * 2; c = (a > 127) ? 1 : 0; end
                    endcase
                    res = res & 255;
                    z = (res == 0) ? 1 : 0;
                    r[rd] = res;
                end
                9: begin r[rd] = in_vals[n_in]; n_in++; end
                10: exp_q.push_back(a);
                11: nxt = int'(w[5:0]);
                12: if (BRANCH_EN && z == 1) nxt = int'(w[5:0]);
                13: if (BRANCH_EN && c == 1) nxt = int'(w[5:0]);
                15: begin halt_pc = pc; return; end
                default: ;
            endcase
            pc = nxt;
        end
    endtask

    // Input source: holds in_valid low for the chosen stall, then one transfer.
    int i_cnt, i_stall;
    bit i_inflight;
    always @(negedge clk) begin
        if (!n_reset) begin
            bus.in_valid = 1'b0; bus.in_data = '0;
            i_cnt = 0; i_inflight = 1'b0; i_stall = pick_istall();
        end else if (i_inflight) begin
            chk("in_single", {31'd0, bus.in_ready}, 32'd0);
            chk("in_ready_len", i_cnt, i_stall + 1);
            i_inflight = 1'b0; i_cnt = 0; i_stall = pick_istall();
            bus.in_valid = 1'b0;
        end else if (bus.in_ready) begin
            i_cnt++;
            if (i_cnt > i_stall) begin
                bus.in_valid = 1'b1;
                bus.in_data  = (in_idx < in_vals.size()) ? BW'(in_vals[in_idx]) : BW'($urandom);
                in_idx++;
                i_inflight = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
                bus.in_data  = BW'($urandom);
            end
        end else begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = BW'($urandom);
        end
    end

    // Output sink and scoreboard monitor.
    int o_cnt, o_stall;
    bit o_hs;
    logic [BW-1:0] o_held;
    always @(negedge clk) begin
        if (!n_reset) begin
            bus.out_ready = 1'b0; o_cnt = 0; o_hs = 1'b0; o_stall = pick_ostall();
        end else if (o_hs) begin
            chk("out_drop", {31'd0, bus.out_valid}, 32'd0);
            o_hs = 1'b0; o_cnt = 0; o_stall = pick_ostall();
            bus.out_ready = 1'b0;
        end else if (o_cnt > 0 || bus.out_valid) begin
            if (o_cnt == 0) begin
                chk("out_pending", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) chk("out_data", bus.out_data, exp_q.pop_front());
                o_held = bus.out_data;
            end else begin
                chk("out_valid_hold", {31'd0, bus.out_valid}, 32'd1);
                chk("out_data_hold", bus.out_data, o_held);
            end
            o_cnt++;
            if (o_cnt > o_stall) begin
                bus.out_ready = 1'b1; o_hs = 1'b1;
            end else begin
                bus.out_ready = 1'b0;
            end
        end else begin
            bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic reset_on();
        @(negedge clk); #2;
        n_reset = 1'b0;
    endtask

    task automatic clear_rom();
        foreach (rom[i]) rom[i] = enc_j(15, 0);
    endtask

    task automatic start_prog();
        model_run(exp_halt_pc, exp_in_cnt);
        in_idx = 0;
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
    endtask

    task automatic finish_prog(input string nm);
        int cyc = 0;
        while (bus.halted !== 1'b1 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_halted"}, {31'd0, bus.halted}, 32'd1);
        chk({nm, "_halt_pc"}, bus.imem_addr, exp_halt_pc);
        chk({nm, "_outs_left"}, exp_q.size(), 32'd0);
        chk({nm, "_in_count"}, in_idx, exp_in_cnt);
    endtask

    task automatic gen_random();
        int op;
        logic [IW-1:0] w;
        clear_rom();
        in_vals.delete();
        for (int k = 0; k < 40; k++) in_vals.push_back(int'($urandom_range(0, 255)));
        for (int p = 0; p < 30; p++) begin
            op = int'($urandom_range(0, 14));
            if (op inside {11, 12, 13}) begin
                rom[p] = enc_j(op, int'($urandom_range(p + 1, 30)));
            end else begin
                w = IW'($urandom);
                w[15:12] = op[3:0];
                rom[p] = w;
            end
        end
        for (int r = 0; r < 8; r++) rom[30 + r] = enc_r(10, 0, r, 0);
        rom[38] = enc_j(15, 0);
    endtask

    initial begin
        int cyc;
        n_reset = 1'b0;
        clear_rom();
        @(posedge clk); #2;
        chk("rst_imem_addr", bus.imem_addr, 32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_halted", {31'd0, bus.halted}, 32'd0);

        // Carry-producing ADD, flag-driven branches, OUT stalled 4 cycles.
        force_ostall = 4;
        rom[0] = enc_i(1, 1, 200);      rom[1] = enc_i(1, 2, 100);
        rom[2] = enc_r(3, 3, 1, 2);     rom[3] = enc_r(10, 0, 3, 0);
        rom[4] = enc_j(13, 8);          rom[5] = enc_i(1, 5, 8'h11);
        rom[6] = enc_r(10, 0, 5, 0);    rom[7] = enc_j(15, 0);
        rom[8] = enc_r(4, 3, 2, 2);     rom[9] = enc_j(12, 12);
        rom[10] = enc_r(10, 0, 1, 0);   rom[11] = enc_j(15, 0);
        rom[12] = enc_r(10, 0, 2, 0);   rom[13] = enc_j(15, 0);
        start_prog();
        finish_prog("progA");
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("halt_frozen", {bus.halted, bus.imem_addr}, {1'b1, exp_halt_pc[5:0]});
        end

        // IN with in_valid held low for 5 cycles.
        reset_on();
        force_ostall = 0; force_istall = 5;
        clear_rom();
        in_vals.delete(); in_vals.push_back(8'hA5);
        rom[0] = enc_r(9, 4, 0, 0); rom[1] = enc_r(10, 0, 4, 0); rom[2] = enc_j(15, 0);
        start_prog();
        finish_prog("in_stall");

        // PC wrap from the top of the ROM.
        reset_on();
        force_istall = -1; force_ostall = -1;
        clear_rom();
        rom[0] = enc_j(11, 63); rom[63] = enc_r(0, 0, 0, 0);
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        cyc = 0;
        while (bus.imem_addr != 6'd63 && cyc < 20) begin @(negedge clk); cyc++; end
        chk("wrap_reach", bus.imem_addr, 32'd63);
        repeat (2) @(negedge clk);
        chk("wrap_pc", bus.imem_addr, (63 + 1) % ROM_DEPTH);

        // Reset pulsed while an OUT waits for the sink.
        reset_on();
        force_ostall = 100;
        clear_rom();
        rom[0] = enc_i(1, 1, 7); rom[1] = enc_r(10, 0, 1, 0); rom[2] = enc_j(15, 0);
        start_prog();
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
        repeat (3) @(negedge clk);
        chk("mid_out_valid_before", {31'd0, bus.out_valid}, 32'd1);
        #2; n_reset = 1'b0; #1;
        chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_imem_addr", bus.imem_addr, 32'd0);
        chk("mid_rst_halted", {31'd0, bus.halted}, 32'd0);
        force_ostall = -1;
        clear_rom();
        for (int r = 0; r < 8; r++) rom[r] = enc_r(10, 0, r, 0);
        rom[8] = enc_j(15, 0);
        start_prog();
        finish_prog("regs_cleared");

        // Randomised straight-line programs with forward jumps only.
        for (int t = 0; t < 10; t++) begin
            reset_on();
            gen_random();
            start_prog();
            finish_prog("random");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
